// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types for the register-bus arbiter: FSM encoding and the
// register offsets of the counter peripheral it fronts.
package reg_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam int unsigned REG_CTRL  = 0;
  localparam int unsigned REG_COUNT = 4;

endpackage

// File: rtl/reg_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: returns the first requester at or
// after ptr, wrapping around, plus a flag telling whether anyone asked.
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  logic [2*N-1:0] req_twice;
  logic [N-1:0]   req_rot;

  // Rotate so that bit 0 is the requester the pointer names.
  always_comb begin
    req_twice = {req, req} >> ptr;
    req_rot   = req_twice[N-1:0];
  end

  always_comb begin
    int idx;
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        grant = IW'(idx);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter serialising single-word requester transactions onto
// the counter peripheral's single-port register bus.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    m_req,
  input  logic [N-1:0]    m_we,
  input  logic [N*AW-1:0] m_addr,
  input  logic [N*DW-1:0] m_wdata,
  output logic [N-1:0]    m_ack,
  output logic [DW-1:0]   m_rdata,
  output logic            s_wr_en,
  output logic            s_rd_en,
  output logic [AW-1:0]   s_addr,
  output logic [DW-1:0]   s_wdata,
  input  logic [DW-1:0]   s_rdata
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t          state, state_next;
  logic [IW-1:0]   rr_ptr, grant, pick_idx;
  logic            pick_valid;
  logic            we_lat;
  logic [AW-1:0]   addr_lat;
  logic [DW-1:0]   wdata_lat;
  logic [DW-1:0]   rdata_lat;

  logic [AW-1:0]   addr_arr  [N];
  logic [DW-1:0]   wdata_arr [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign addr_arr[gi]  = m_addr[gi*AW +: AW];
    assign wdata_arr[gi] = m_wdata[gi*DW +: DW];
  end

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req   (m_req),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = ISSUE;
      ISSUE:   state_next = we_lat ? ACK : CAPT;
      CAPT:    state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The latched request doubles as the slave address/data, so both simply
  // hold their last value outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      grant     <= '0;
      we_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      rdata_lat <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant     <= pick_idx;
        we_lat    <= m_we[pick_idx];
        addr_lat  <= addr_arr[pick_idx];
        wdata_lat <= wdata_arr[pick_idx];
      end
      if (state == CAPT) rdata_lat <= s_rdata;
      if (state == ACK) rr_ptr <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
    end
  end

  // Strobes and ack decode straight from state so reset removes them at once.
  always_comb begin
    m_ack   = '0;
    s_wr_en = 1'b0;
    s_rd_en = 1'b0;
    if (state == ISSUE) begin
      s_wr_en = we_lat;
      s_rd_en = !we_lat;
    end
    if (state == ACK) m_ack[grant] = 1'b1;
  end

  assign m_rdata = rdata_lat;
  assign s_addr  = addr_lat;
  assign s_wdata = wdata_lat;

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Randomised bench for reg_bus_arbiter with a transaction-level reference
// model and a small behavioural counter-peripheral slave.
module tb_reg_bus_arbiter;
  import reg_bus_arbiter_pkg::*;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    m_req = '0;
  logic [N-1:0]    m_we = '0;
  logic [N*AW-1:0] m_addr = '0;
  logic [N*DW-1:0] m_wdata = '0;
  logic [N-1:0]    m_ack;
  logic [DW-1:0]   m_rdata;
  logic            s_wr_en, s_rd_en;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [DW-1:0]   s_rdata = '0;

  always #5 clk = ~clk;

  reg_bus_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .s_wr_en(s_wr_en), .s_rd_en(s_rd_en), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_rdata(s_rdata)
  );

  typedef struct {
    int            who;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          pend[$];
  txn_t          cur[N];
  int            served[$];
  logic [DW-1:0] slave_mem[1 << AW];

  int n_checks = 0, n_pass = 0, cyc = 0, n_txn = 0;
  bit random_gaps = 1'b0;

  // Reference model state: one transaction in flight at most.
  bit            inflight = 1'b0;
  bit            m_read = 1'b0;
  int            m_idx = 0, strobe_cyc = 0, ack_cyc = 0, idle_from = 0, ptr = 0;
  logic [DW-1:0] last_rdata = '0, exp_rdata = '0;
  bit            rd_prev = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic slave_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    slave_mem[a] = d;
    if (a == AW'(REG_CTRL) && d[1]) slave_mem[AW'(REG_COUNT)] = '0;
  endtask

  task automatic push(input int who, input logic we, input int addr, input logic [DW-1:0] wdata);
    txn_t t;
    t.who = who; t.we = we; t.addr = AW'(addr); t.wdata = wdata;
    pend.push_back(t);
  endtask

  // One clock: check outputs of the cycle just ending, then drive requesters,
  // then let the model arbitrate on the edge that follows.
  task automatic step();
    logic [N-1:0]  exp_ack;
    logic          exp_wr, exp_rd;
    logic [DW-1:0] exp_md;
    @(negedge clk);
    cyc++;
    exp_ack = '0; exp_wr = 1'b0; exp_rd = 1'b0;
    if (inflight && cyc == strobe_cyc) begin exp_wr = !m_read; exp_rd = m_read; end
    if (inflight && cyc == ack_cyc) exp_ack[m_idx] = 1'b1;
    chk("s_wr_en", s_wr_en, exp_wr);
    chk("s_rd_en", s_rd_en, exp_rd);
    chk("m_ack", m_ack, exp_ack);
    if (exp_wr || exp_rd) begin
      chk("s_addr", s_addr, cur[m_idx].addr);
      if (exp_wr) begin
        chk("s_wdata", s_wdata, cur[m_idx].wdata);
        slave_write(cur[m_idx].addr, cur[m_idx].wdata);
      end else begin
        exp_rdata = slave_mem[cur[m_idx].addr];
      end
    end
    // Slave read data is only trustworthy the cycle after the read strobe.
    if (exp_rd) s_rdata = slave_mem[cur[m_idx].addr];
    else if (!rd_prev) s_rdata = $urandom;
    rd_prev = exp_rd;

    exp_md = (exp_ack != '0 && m_read) ? exp_rdata : last_rdata;
    chk("m_rdata", m_rdata, exp_md);
    if (exp_ack != '0) begin
      last_rdata = exp_md;
      n_txn++;
      $display("txn %0d: req%0d %s addr=0x%0h data=0x%0h cycle=%0d", n_txn, m_idx,
               m_read ? "RD" : "WR", cur[m_idx].addr, m_read ? exp_md : cur[m_idx].wdata, cyc);
      served.push_back(m_idx);
      ptr = (m_idx + 1) % N;
      inflight = 1'b0;
      idle_from = cyc + 1;
    end

    for (int i = 0; i < N; i++) begin
      if (m_req[i] && exp_ack[i]) m_req[i] = 1'b0;
      if (!m_req[i]) begin
        int j = -1;
        foreach (pend[k]) if (j < 0 && pend[k].who == i) j = k;
        if (j >= 0 && !(random_gaps && $urandom_range(3) == 0)) begin
          cur[i] = pend[j];
          pend.delete(j);
          m_req[i] = 1'b1;
          m_we[i] = cur[i].we;
          m_addr[i*AW +: AW] = cur[i].addr;
          m_wdata[i*DW +: DW] = cur[i].wdata;
        end else begin
          m_we[i] = 1'($urandom);
          m_addr[i*AW +: AW] = AW'($urandom);
          m_wdata[i*DW +: DW] = $urandom;
        end
      end
    end

    if (!inflight && cyc >= idle_from && m_req != '0) begin
      for (int k = 0; k < N; k++) begin
        if (m_req[(ptr + k) % N]) begin
          m_idx = (ptr + k) % N;
          break;
        end
      end
      m_read = !cur[m_idx].we;
      strobe_cyc = cyc + 1;
      ack_cyc = cyc + (m_read ? 3 : 2);
      inflight = 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while ((pend.size() != 0 || inflight || m_req != '0) && b < budget) begin
      step();
      b++;
    end
    chk("drain_timeout", 64'(b < budget), 64'd1);
  endtask

  // Reset may be applied at any time, not only on an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    m_req = '0;
    pend.delete();
    inflight = 1'b0;
    ptr = 0;
    last_rdata = '0;
    #1;
    chk("rst_wr_en", s_wr_en, 1'b0);
    chk("rst_rd_en", s_rd_en, 1'b0);
    chk("rst_ack", m_ack, '0);
    chk("rst_rdata", m_rdata, '0);
    chk("rst_addr", s_addr, '0);
    chk("rst_wdata", s_wdata, '0);
    repeat (2) begin
      @(negedge clk);
      cyc++;
      chk("rst_hold_ack", m_ack, '0);
      chk("rst_hold_strb", {s_wr_en, s_rd_en}, 2'b00);
    end
    rst_n = 1'b1;
    idle_from = cyc + 1;
    rd_prev = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int b, base, pushed;
    for (int a = 0; a < (1 << AW); a++) slave_mem[a] = '0;

    // Reset, then a few idle cycles with nothing requested.
    do_reset();
    repeat (3) step();

    // Async reset while a write is on the bus.
    push(0, 1'b1, 12, 32'h0000_00AA);
    b = 0;
    while (!(inflight && cyc + 1 == strobe_cyc) && b < 20) begin step(); b++; end
    @(posedge clk); #2;
    chk("issue_wr_before_rst", s_wr_en, 1'b1);
    do_reset();

    // Single write, then single read returning 5 from COUNT.
    push(0, 1'b1, REG_CTRL, 32'h1);
    drain(50);
    slave_mem[REG_COUNT] = 32'h5;
    push(1, 1'b0, REG_COUNT, '0);
    drain(50);
    chk("single_read_val", m_rdata, 32'h5);

    // Contention from rr=0: grants must alternate.
    base = served.size();
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b1, 8, DW'(k));
      push(1, 1'b0, 8, '0);
    end
    drain(100);
    for (int k = 0; k < 6; k++) chk("rr_order", 64'(served[base + k]), 64'(k % 2));

    // Clear sequence: write CTRL clear bit then read COUNT back as zero.
    slave_mem[REG_COUNT] = 32'h7;
    push(0, 1'b1, REG_CTRL, 32'h2);
    drain(50);
    push(1, 1'b0, REG_COUNT, '0);
    drain(50);
    chk("clear_read_val", m_rdata, 32'h0);

    // Reset during CAPT: no ack, pointer back to requester 0.
    push(0, 1'b1, 16, 32'h3);
    drain(50);
    push(1, 1'b0, 16, '0);
    b = 0;
    while (!(inflight && m_idx == 1 && cyc == strobe_cyc) && b < 20) begin step(); b++; end
    @(posedge clk); #2;
    do_reset();
    base = served.size();
    push(1, 1'b1, 20, 32'h11);
    push(0, 1'b1, 20, 32'h22);
    drain(50);
    chk("post_rst_first_grant", 64'(served[base]), 64'd0);

    // Randomised traffic with idle gaps.
    random_gaps = 1'b1;
    pushed = 0;
    for (int c = 0; c < 4000 && pushed < 300; c++) begin
      if ($urandom_range(99) < 40) begin
        push($urandom_range(N - 1), 1'($urandom), $urandom_range(7) * 4,
             ($urandom_range(1) == 0) ? DW'($urandom_range(3)) : DW'($urandom));
        pushed++;
      end
      step();
    end
    drain(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Round-robin arbiter that shares the single-port register bus of the counter peripheral (wr_en/rd_en/addr/wdata/rdata) between N requesters, e.g. CPU-side config master and an autonomous poll engine.
- Each requester issues one single-word read or write through a req/ack handshake; the arbiter serialises them onto the slave bus and returns read data.
- Sits directly between the requesters and the peripheral's bus ports.

Parameters:
- N, 2, number of requesters (>=2)
- AW, 10, address width
- DW, 32, data width

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- m_req  input  N  per-requester request; held high until ack
- m_we  input  N  per-requester: 1 = write, 0 = read
- m_addr  input  N*AW  packed addresses, requester i at [i*AW +: AW]
- m_wdata  input  N*DW  packed write data, requester i at [i*DW +: DW]
- m_ack  output  N  one-cycle completion pulse to the granted requester
- m_rdata  output  DW  read data, broadcast; valid in the m_ack cycle
- s_wr_en  output  1  slave write strobe
- s_rd_en  output  1  slave read strobe
- s_addr  output  AW  slave address
- s_wdata  output  DW  slave write data
- s_rdata  input  DW  slave read data, valid the cycle after s_rd_en

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr pointer=0, grant=0. m_ack=0, m_rdata=0, s_wr_en=0, s_rd_en=0, s_addr=0, s_wdata=0. Strobes drop immediately, not at the next edge.
- FSM states: IDLE, ISSUE, CAPT, ACK.
- IDLE: if any m_req is high, pick the first requester at or after the rr pointer (wrap-around search). Latch grant index, we, addr and wdata into internal registers, then go to ISSUE. If no request, stay in IDLE.
- ISSUE: exactly one cycle with s_wr_en=we or s_rd_en=!we, and s_addr/s_wdata driven from the latched values. Writes go to ACK; reads go to CAPT.
- CAPT: s_rd_en=0. Register s_rdata into m_rdata on the edge leaving CAPT. Go to ACK.
- ACK: m_ack[grant]=1 for one cycle. Set rr pointer to (grant+1) mod N. Return to IDLE.
- Strobes are 0 in every state except ISSUE. s_addr/s_wdata hold their last value outside ISSUE.
- m_rdata holds its value until the next read completes. Writes do not change m_rdata.
- Latency, counted from the IDLE edge that samples req: write ack 2 cycles later, read ack 3 cycles later. The bus is back in IDLE 1 cycle after ack.
- Throughput: one transaction per 3 cycles for writes, 4 for reads.
- Requester rules:
  - Hold req, we, addr and wdata stable until the ack is sampled.
  - Drop req on the same edge that samples ack=1.
  - A req still high in IDLE after that edge is treated as a new request.
- Simultaneous requests: the rr pointer decides. With N=2 and both requesters continuously requesting, grants strictly alternate, so there is no starvation.
- A requester deasserting req before ack is a protocol violation. The arbiter still completes the latched transaction and pulses ack.
- Addresses are forwarded unchanged, with no alignment check or decode.
- Reset mid-operation: the in-flight transaction is aborted and no ack is given. A write already strobed in ISSUE before reset counts as performed at the slave.

Decomposition:
- Shared package: FSM state enum (IDLE, ISSUE, CAPT, ACK, 2-bit encoding) and the peripheral register offsets (CTRL=0, COUNT=4).
- Sub-module rr_picker (combinational): inputs req vector and pointer, outputs grant index and a valid flag. Reusable by other arbiters.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then no req → all outputs 0. Assert rst_n=0 asynchronously mid-cycle while in ISSUE → s_wr_en falls without waiting for a clock edge.
- Single write: m_req[0]=1, we=1, addr=0, wdata=0x1 → s_wr_en=1 with s_addr=0, s_wdata=0x1 for exactly one cycle; m_ack[0] 2 cycles after the sampling edge.
- Single read: requester 1 reads addr 4 while the slave returns 0x00000005 → s_rd_en pulses once; m_ack[1] 3 cycles after sampling, with m_rdata=0x00000005.
- Contention: both requesters request on the same edge from reset (rr=0) → requester 0 served first, then requester 1. With both held continuously for 6 transactions, grants go 0,1,0,1,0,1 and no two strobes overlap.
- Clear sequence: requester 0 writes 0x2 to addr 0, then requester 1 reads addr 4 → write strobe precedes read strobe; m_rdata equals the slave's post-clear value of 0x0.
- Reset mid-read: deassert rst_n during CAPT → no m_ack is pulsed; after release the next request is served by requester 0 (rr=0).
